dram_write_master: RTL and testbench



---
 rtl/dram_write_master.sv | 210 +++++++++++++++++++++
 tb/tb_dram_write_master.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_write_master.sv
// dram_write_master: drains a first-word-fall-through FIFO into DRAM as AXI4 INCR write
// bursts. Only one burst is in flight at a time. A burst never crosses a 4 KB page. The
// write address wraps inside the frame region [DRAM_ADDR_BASE, DRAM_ADDR_BASE+REGION_SIZE).
// Optional feature: define DRAM_WRITE_ERR_CNT_EN to count non-OKAY write responses on
// bresp_err_cnt. When it is undefined, bresp_err_cnt is tied to zero.
module dram_write_master #(
    parameter int unsigned                DRAM_ADDR_WIDTH  = 32,
    parameter logic [DRAM_ADDR_WIDTH-1:0] DRAM_ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned                DRAM_DATA_WIDTH  = 512,
    parameter int unsigned                BURST_LEN        = 16,
    parameter logic [DRAM_ADDR_WIDTH-1:0] REGION_SIZE      = 32'h0100_0000,
    parameter int unsigned                FIFO_COUNT_WIDTH = 10
) (
    input  logic                           dram_ctrl_clk,
    input  logic                           reset_n,
    input  logic [DRAM_DATA_WIDTH-1:0]     fifo_dout,
    input  logic                           fifo_empty,
    input  logic [FIFO_COUNT_WIDTH-1:0]    fifo_count,
    output logic                           fifo_rd_en,
    input  logic                           flush,
    output logic [DRAM_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                     m_axi_awlen,
    output logic [2:0]                     m_axi_awsize,
    output logic [1:0]                     m_axi_awburst,
    output logic                           m_axi_awvalid,
    input  logic                           m_axi_awready,
    output logic [DRAM_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DRAM_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                           m_axi_wlast,
    output logic                           m_axi_wvalid,
    input  logic                           m_axi_wready,
    input  logic [1:0]                     m_axi_bresp,
    input  logic                           m_axi_bvalid,
    output logic                           m_axi_bready,
    output logic                           busy,
    output logic [15:0]                    bresp_err_cnt
);

    localparam int unsigned AddrW     = DRAM_ADDR_WIDTH;
    localparam int unsigned BeatBytes = DRAM_DATA_WIDTH / 8;
    localparam int unsigned BeatShift = $clog2(BeatBytes);
    localparam logic [AddrW:0] RegionEnd = {1'b0, DRAM_ADDR_BASE} + {1'b0, REGION_SIZE};
    localparam logic [FIFO_COUNT_WIDTH-1:0] FullCnt = FIFO_COUNT_WIDTH'(BURST_LEN);
    localparam logic [8:0] FullLen = 9'(BURST_LEN);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e             state_q, state_d;
    logic [AddrW-1:0]   cur_addr_q, cur_addr_d;
    logic [8:0]         len_q, len_d;
    logic [7:0]         beat_q, beat_d;
    logic               flush_pending_q, flush_pending_d;
    logic               awvalid_q, awvalid_d;
    logic [7:0]         awlen_q, awlen_d;
    logic               bready_q, bready_d;
    logic               busy_q, busy_d;

    logic               full_avail, cnt_nz, take_full, take_part;
    logic [8:0]         req_len, burst_len;
    logic [12:0]        page_room;
    logic [AddrW:0]     addr_sum;
    logic [AddrW-1:0]   addr_next;
    logic               w_hs, last_beat;

    // Burst sizing: a full burst has priority over a flush drain.
    assign full_avail = (fifo_count >= FullCnt);
    assign cnt_nz     = (fifo_count != '0);
    assign take_full  = (state_q == StIdle) && full_avail;
    // A flush arriving this very cycle counts as pending, so a drain starts without delay.
    assign take_part  = (state_q == StIdle) && !full_avail && cnt_nz
                        && (flush_pending_q || flush);
    // When no full burst is possible, fifo_count is below BURST_LEN and fits in 9 bits.
    assign req_len    = full_avail ? FullLen : 9'(fifo_count);
    // Beats left before the next 4 KB page boundary.
    assign page_room  = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> BeatShift;
    assign burst_len  = (page_room < {4'b0, req_len}) ? page_room[8:0] : req_len;

    // Address of the next burst. The sum is one bit wider so that the wrap test cannot overflow.
    assign addr_sum  = {1'b0, cur_addr_q} + ((AddrW+1)'(len_q) << BeatShift);
    assign addr_next = (addr_sum >= RegionEnd) ? DRAM_ADDR_BASE : addr_sum[AddrW-1:0];

    // W channel follows the FIFO head directly; an empty FIFO only stalls.
    assign m_axi_wvalid  = (state_q == StData) && !fifo_empty;
    assign w_hs          = m_axi_wvalid && m_axi_wready;
    assign fifo_rd_en    = w_hs;
    assign last_beat     = ({1'b0, beat_q} == (len_q - 9'd1));
    assign m_axi_wlast   = (state_q == StData) && last_beat;
    assign m_axi_wdata   = (state_q == StData) ? fifo_dout : '0;
    assign m_axi_wstrb   = '1;

    assign m_axi_awaddr  = cur_addr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'(BeatShift);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_bready  = bready_q;
    assign busy          = busy_q;

    // Next-state logic for the burst FSM and its registered outputs.
    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        len_d           = len_q;
        beat_d          = beat_q;
        flush_pending_d = flush_pending_q;
        awvalid_d       = awvalid_q;
        awlen_d         = awlen_q;
        bready_d        = bready_q;

        if (take_part) begin
            flush_pending_d = 1'b0;
        end else if (flush) begin
            flush_pending_d = 1'b1;
        end else if ((state_q == StIdle) && !cnt_nz) begin
            flush_pending_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (take_full || take_part) begin
                    state_d   = StAddr;
                    len_d     = burst_len;
                    awlen_d   = 8'(burst_len - 9'd1);
                    awvalid_d = 1'b1;
                end
            end
            StAddr: begin
                if (m_axi_awready) begin
                    awvalid_d = 1'b0;
                    beat_d    = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (w_hs) begin
                    if (last_beat) begin
                        state_d  = StResp;
                        bready_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            StResp: begin
                if (m_axi_bvalid) begin
                    bready_d   = 1'b0;
                    cur_addr_d = addr_next;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and registered outputs. Reset aborts any burst that is in flight.
    always_ff @(posedge dram_ctrl_clk) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            cur_addr_q      <= DRAM_ADDR_BASE;
            len_q           <= '0;
            beat_q          <= '0;
            flush_pending_q <= 1'b0;
            awvalid_q       <= 1'b0;
            awlen_q         <= '0;
            bready_q        <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            len_q           <= len_d;
            beat_q          <= beat_d;
            flush_pending_q <= flush_pending_d;
            awvalid_q       <= awvalid_d;
            awlen_q         <= awlen_d;
            bready_q        <= bready_d;
            busy_q          <= busy_d;
        end
    end

`ifdef DRAM_WRITE_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating count of B handshakes that carry a non-OKAY response.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == StResp) && m_axi_bvalid && (m_axi_bresp != 2'b00)
            && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Register for the error counter.
    always_ff @(posedge dram_ctrl_clk) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bresp_err_cnt = err_cnt_q;
`else
    logic unused_bresp;
    assign unused_bresp  = ^m_axi_bresp;
    assign bresp_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dram_write_master.sv
// tb_dram_write_master: directed sequence with randomized data and handshakes. The bench
// models the FIFO as a queue. A burst-level reference plans the expected AW addresses and
// lengths from the FIFO fill level and flush requests. A scoreboard checks the W data order.
// The region is shrunk to 8 KB so that the address wrap is reached in a few hundred cycles.
module tb_dram_write_master;
    localparam logic [31:0] Base      = 32'h8000_0000;
    localparam logic [31:0] Region    = 32'h0000_2000;
    localparam int          BurstLen  = 16;
    localparam int          BeatBytes = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [511:0]  fifo_dout;
    logic          fifo_empty;
    logic [9:0]    fifo_count;
    logic          fifo_rd_en;
    logic          flush;
    logic [31:0]   m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [511:0]  m_axi_wdata;
    logic [63:0]   m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic          busy;
    logic [15:0]   bresp_err_cnt;

    always #5 clk = ~clk;

    dram_write_master #(
        .DRAM_ADDR_WIDTH (32),
        .DRAM_ADDR_BASE  (Base),
        .DRAM_DATA_WIDTH (512),
        .BURST_LEN       (BurstLen),
        .REGION_SIZE     (Region),
        .FIFO_COUNT_WIDTH(10)
    ) dut (
        .dram_ctrl_clk(clk),
        .reset_n      (reset_n),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .fifo_rd_en   (fifo_rd_en),
        .flush        (flush),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awlen  (m_axi_awlen),
        .m_axi_awsize (m_axi_awsize),
        .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wlast  (m_axi_wlast),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_bresp  (m_axi_bresp),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready),
        .busy         (busy),
        .bresp_err_cnt(bresp_err_cnt)
    );

    typedef struct { logic [31:0] addr; int len; } burst_t;

    int total = 0;
    int bad = 0;

    logic [511:0] fifo_q[$];
    logic [511:0] exp_data[$];
    burst_t       exp_bursts[$];

    // Burst-level reference state.
    logic [31:0] m_addr;
    int          m_cnt;
    bit          m_pend;
    int          m_err;

    // Monitor state.
    int          phase;     // 0: no burst, 1: AW accepted, 2: waiting for B
    int          beat;
    int          cur_len;
    int          n_pops;
    int          cyc;
    int          load_cyc;
    int          aw_rise_cyc;
    int          b_cyc;
    bit          prev_awvalid;
    bit          b_owed;
    logic [31:0] last_awaddr;
    logic [7:0]  last_awlen;

    // Stimulus modes.
    bit rand_rdy;
    bit toggle_empty;
    bit mask_now;
    int bresp_mode;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_err();
`ifdef DRAM_WRITE_ERR_CNT_EN
        return (m_err > 65535) ? 65535 : m_err;
`else
        return 0;
`endif
    endfunction

    function automatic logic [511:0] rand_word();
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic apply_inputs();
        fifo_count = 10'(fifo_q.size());
        fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        fifo_empty = (fifo_q.size() == 0) || mask_now;
    endtask

    // Push n words, optionally with a flush pulse, and plan the bursts they must produce.
    task automatic model_load(input int n, input bit fl);
        logic [511:0] w;
        int len;
        int room;
        bit full;
        for (int i = 0; i < n; i++) begin
            w = rand_word();
            fifo_q.push_back(w);
            exp_data.push_back(w);
        end
        m_cnt += n;
        if (fl) m_pend = 1'b1;
        while (m_cnt >= BurstLen || (m_pend && m_cnt > 0)) begin
            full = (m_cnt >= BurstLen);
            len  = full ? BurstLen : m_cnt;
            room = (4096 - int'(m_addr % 4096)) / BeatBytes;
            if (len > room) len = room;
            exp_bursts.push_back('{m_addr, len});
            m_cnt -= len;
            if (!full) m_pend = 1'b0;
            m_addr = m_addr + 32'(len * BeatBytes);
            if (m_addr >= Base + Region) m_addr = Base;
        end
        if (m_cnt == 0) m_pend = 1'b0;
        flush       = fl;
        aw_rise_cyc = -1;
        load_cyc    = cyc;
        apply_inputs();
    endtask

    // One clock: check at the falling edge, update the FIFO and drive new inputs after the
    // rising edge.
    task automatic cycle();
        burst_t e;
        bit     rd_seen;
        @(negedge clk);
        cyc++;
        if (m_axi_awvalid && !prev_awvalid) begin
            if (aw_rise_cyc < 0) aw_rise_cyc = cyc;
            if (b_cyc >= 0) chk("aw_gap_after_b", (cyc - b_cyc) >= 2, 1'b1);
        end
        prev_awvalid = m_axi_awvalid;
        chk("rd_en_is_w_hs", fifo_rd_en, m_axi_wvalid && m_axi_wready);
        if (fifo_empty) chk("wvalid_when_empty", m_axi_wvalid, 1'b0);
        if (m_axi_wvalid) chk("w_after_aw", phase == 1, 1'b1);
        if (m_axi_bready) chk("bready_after_wlast", phase == 2, 1'b1);
        if (m_axi_awvalid && m_axi_awready) begin
            chk("aw_phase", phase == 0, 1'b1);
            chk("aw_planned", exp_bursts.size() > 0, 1'b1);
            if (exp_bursts.size() > 0) begin
                e = exp_bursts.pop_front();
                chk("awaddr", m_axi_awaddr, e.addr);
                chk("awlen", m_axi_awlen, 8'(e.len - 1));
                chk("awsize", m_axi_awsize, 3'b110);
                chk("awburst", m_axi_awburst, 2'b01);
                cur_len = e.len;
            end
            last_awaddr = m_axi_awaddr;
            last_awlen  = m_axi_awlen;
            phase       = 1;
            beat        = 0;
        end
        if (m_axi_wvalid && m_axi_wready) begin
            chk("wdata_avail", exp_data.size() > 0, 1'b1);
            if (exp_data.size() > 0) chk("wdata", m_axi_wdata, exp_data.pop_front());
            chk("wlast", m_axi_wlast, beat == cur_len - 1);
            chk("wstrb", m_axi_wstrb, {64{1'b1}});
            if (beat == cur_len - 1) begin
                phase  = 2;
                b_owed = 1'b1;
            end
            beat++;
        end
        if (m_axi_bvalid && m_axi_bready) begin
            if (m_axi_bresp != 2'b00) m_err++;
            phase  = 0;
            b_owed = 1'b0;
            b_cyc  = cyc;
        end
        rd_seen = fifo_rd_en;
        @(posedge clk);
        #1;
        if (rd_seen && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            n_pops++;
        end
        if (rand_rdy) begin
            m_axi_awready = 1'($urandom_range(0, 1));
            m_axi_wready  = ($urandom_range(0, 3) != 0);
        end else begin
            m_axi_awready = 1'b1;
            m_axi_wready  = 1'b1;
        end
        if (toggle_empty) mask_now = !mask_now;
        else if (rand_rdy) mask_now = ($urandom_range(0, 4) == 0);
        else mask_now = 1'b0;
        if (!b_owed) begin
            m_axi_bvalid = 1'b0;
        end else if (!m_axi_bvalid) begin
            m_axi_bvalid = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bresp_mode == 0) m_axi_bresp = 2'b00;
            else if (bresp_mode == 1) m_axi_bresp = 2'b10;
            else m_axi_bresp = 2'($urandom_range(0, 3));
        end
        flush = 1'b0;
        apply_inputs();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_bursts.size() > 0 || phase != 0 || busy) && n < 3000) begin
            cycle();
            n++;
        end
        chk("drain_in_time", n < 3000, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("fifo_level", fifo_q.size(), m_cnt);
        chk("err_cnt", bresp_err_cnt, exp_err());
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        flush         = 1'b0;
        mask_now      = 1'b0;
        apply_inputs();
        @(posedge clk);
        #1;
        chk("rst_wvalid", m_axi_wvalid, 1'b0);
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_awaddr", m_axi_awaddr, Base);
        chk("rst_awvalid", m_axi_awvalid, 1'b0);
        chk("rst_bready", m_axi_bready, 1'b0);
        chk("rst_wlast", m_axi_wlast, 1'b0);
        chk("rst_awlen", m_axi_awlen, 8'd0);
        chk("rst_wdata", m_axi_wdata, 512'd0);
        chk("rst_err_cnt", bresp_err_cnt, 16'd0);
        fifo_q.delete();
        exp_data.delete();
        exp_bursts.delete();
        m_addr       = Base;
        m_cnt        = 0;
        m_pend       = 1'b0;
        m_err        = 0;
        phase        = 0;
        beat         = 0;
        b_owed       = 1'b0;
        b_cyc        = -1;
        prev_awvalid = 1'b0;
        apply_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int pops0;
        int n;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        flush         = 1'b0;
        mask_now      = 1'b0;
        rand_rdy      = 1'b0;
        toggle_empty  = 1'b0;
        bresp_mode    = 0;
        cyc           = 0;
        n_pops        = 0;
        cur_len       = 0;
        aw_rise_cyc   = -1;
        load_cyc      = 0;
        last_awaddr   = '0;
        last_awlen    = '0;
        apply_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // Full burst with every handshake ready. awvalid rises the cycle after the fill
        // level first reaches 16.
        pops0 = n_pops;
        model_load(16, 1'b0);
        drain();
        chk("t1_aw_latency", aw_rise_cyc - load_cyc, 2);
        chk("t1_awaddr", last_awaddr, 32'h8000_0000);
        chk("t1_awlen", last_awlen, 8'd15);
        chk("t1_pops", n_pops - pops0, 16);

        // Flush drains the 5 residual words, and the pending flush is then cleared.
        pops0 = n_pops;
        model_load(5, 1'b1);
        drain();
        chk("t2_awaddr", last_awaddr, 32'h8000_0400);
        chk("t2_awlen", last_awlen, 8'd4);
        chk("t2_pops", n_pops - pops0, 5);
        model_load(3, 1'b0);
        repeat (20) cycle();
        chk("t2_flush_cleared", busy, 1'b0);
        chk("t2_no_aw", aw_rise_cyc < 0, 1'b1);
        chk("t2_fifo_kept", fifo_count, 10'd3);

        // FIFO empty flag toggling during DATA.
        toggle_empty = 1'b1;
        pops0 = n_pops;
        model_load(13, 1'b0);
        drain();
        toggle_empty = 1'b0;
        chk("t3_pops", n_pops - pops0, 16);
        chk("t3_awaddr", last_awaddr, 32'h8000_0540);

        // Random handshakes. A flush that coincides with a full burst is handled after it.
        rand_rdy = 1'b1;
        model_load(24, 1'b1);
        drain();
        chk("t4_awaddr", last_awaddr, 32'h8000_0D40);
        chk("t4_awlen", last_awlen, 8'd7);
        // Start at 0xF40: the burst is clipped to 3 beats at the 4 KB page boundary.
        model_load(16, 1'b0);
        drain();
        chk("t4_clip_awaddr", last_awaddr, 32'h8000_0F40);
        chk("t4_clip_awlen", last_awlen, 8'd2);
        model_load(3, 1'b0);
        drain();
        chk("t4_page_awaddr", last_awaddr, 32'h8000_1000);

        // Three SLVERR responses, then the wrap back to the region base.
        bresp_mode = 1;
        model_load(48, 1'b0);
        drain();
`ifdef DRAM_WRITE_ERR_CNT_EN
        chk("t5_err3", bresp_err_cnt, 16'd3);
`else
        chk("t5_err0", bresp_err_cnt, 16'd0);
`endif
        bresp_mode = 2;
        model_load(16, 1'b0);
        drain();
        chk("t5_wrap_awaddr", last_awaddr, Base);

        // Reset during the data phase, at beat 7.
        rand_rdy   = 1'b0;
        bresp_mode = 0;
        model_load(16, 1'b0);
        n = 0;
        while (!(phase == 1 && beat == 7) && n < 200) begin
            cycle();
            n++;
        end
        chk("t6_reach_beat7", n < 200, 1'b1);
        do_reset();

        // Normal operation after the abort resumes from the region base.
        model_load(16, 1'b0);
        drain();
        chk("t7_awaddr", last_awaddr, Base);
        chk("t7_awlen", last_awlen, 8'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
